alu_ctrl_mdu: RTL and testbench

- Parametrised successor of the EX-stage ALU control decoder.
- Decodes ALUOp/funct7/funct3 into the 4-bit ALU control code, with added load/store, branch and SLT/SLTU decodes.
- Adds an iterative RV32M multiply/divide unit (MDU) with stall handshake to the pipeline hazard logic.
- Sits in EX, between the ID/EX register and the ALU/EX-MEM mux.

---
 rtl/alu_ctrl_mdu_pkg.sv | 61 ++++++
 rtl/alu_ctrl_mdu_core.sv | 78 +++++++
 rtl/alu_ctrl_mdu.sv | 75 +++++++
 tb/tb_alu_ctrl_mdu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_mdu_pkg.sv
// alu_ctrl_mdu_pkg: ALU control codes, ALUOp/funct7/funct3 constants and MDU FSM states
// shared by the EX-stage decoder and its multiply/divide unit.
package alu_ctrl_mdu_pkg;
   localparam logic [3:0] ALU_XOR  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_MDU  = 4'b1110;
   localparam logic [3:0] ALU_BAD  = 4'b1111;

   localparam logic [2:0] OP_LS = 3'b000;
   localparam logic [2:0] OP_BR = 3'b001;
   localparam logic [2:0] OP_R  = 3'b010;
   localparam logic [2:0] OP_I  = 3'b011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} mdu_state_e;

   // Codes shared by R-type (funct7 BASE) and I-type; shifts default to logical.
   function automatic logic [3:0] base_code(input logic [2:0] f3);
      logic [3:0] c;
      case (f3)
         F3_ADD:  c = ALU_ADD;
         F3_SLL:  c = ALU_SLL;
         F3_SLT:  c = ALU_SLT;
         F3_SLTU: c = ALU_SLTU;
         F3_XOR:  c = ALU_XOR;
         F3_SR:   c = ALU_SRL;
         F3_OR:   c = ALU_OR;
         default: c = ALU_AND;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/alu_ctrl_mdu_core.sv
// mdu_core: operand registers, iteration counter, shift-add multiplier / restoring divider
// on unsigned magnitudes, and the sign fix-up into the result register.
module mdu_core
   import alu_ctrl_mdu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            run,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            special,
   output logic            last,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam int PW = XLEN + MUL_BITS;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [2:0]        f3_q;
   logic              neg_q, neg_r;
   logic [XLEN-1:0]   opd;
   logic [2*XLEN-1:0] acc, acc_nxt, prod;
   logic [CW-1:0]     cnt;
   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b, spec_val, q_fix, r_fix, fixed;
   logic [PW-1:0]     mul_sum;
   logic [XLEN:0]     div_try, div_sub;

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      sign_a   = rs1[XLEN-1] & (funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11);
      sign_b   = rs2[XLEN-1] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
      mag_a    = sign_a ? -rs1 : rs1;
      mag_b    = sign_b ? -rs2 : rs2;
      special  = funct3[2] & (rs2 == '0 | (~funct3[0] & rs1 == MIN & rs2 == '1));
      spec_val = funct3[1] ? (rs2 == '0 ? rs1 : '0) : (rs2 == '0 ? '1 : rs1);
      mul_sum  = PW'(acc[2*XLEN-1:XLEN]) + PW'(opd) * PW'(acc[MUL_BITS-1:0]);
      div_try  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_sub  = div_try - {1'b0, opd};
      acc_nxt  = ~f3_q[2] ? {mul_sum, acc[XLEN-1:MUL_BITS]}
               : div_sub[XLEN] ? {div_try[XLEN-1:0], acc[XLEN-2:0], 1'b0}
               : {div_sub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      prod     = neg_q ? -acc_nxt : acc_nxt;
      q_fix    = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      r_fix    = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      fixed    = f3_q[2] ? (f3_q[1] ? r_fix : q_fix)
               : (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
      last     = cnt == (f3_q[2] ? CW'(XLEN-1) : CW'(XLEN/MUL_BITS-1));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         f3_q   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         opd    <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (start) begin
         f3_q  <= funct3;
         neg_q <= sign_a ^ sign_b;
         neg_r <= sign_a;
         opd   <= funct3[2] ? mag_b : mag_a;
         acc   <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
         cnt   <= '0;
         if (special) result <= spec_val;
      end else if (run) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (last) result <= fixed;
      end
endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decoder with an iterative RV32M multiply/divide unit
// that stalls the pipeline while it works.
module alu_ctrl_mdu
   import alu_ctrl_mdu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALUOP_W  = 3,
   parameter int MUL_BITS = 1
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [6:0]         funct7_i,
   input  logic [2:0]         funct3_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic               valid_i,
   input  logic               flush_i,
   input  logic [XLEN-1:0]    rs1_data_i,
   input  logic [XLEN-1:0]    rs2_data_i,
   output logic [3:0]         ALUCtrl_o,
   output logic               mdu_busy_o,
   output logic               mdu_done_o,
   output logic [XLEN-1:0]    mdu_result_o
);
   mdu_state_e state, nxt;
   logic is_m, accept, run, special, last;

   always_comb begin
      ALUCtrl_o = ALU_BAD;
      if (ALUOp_i == ALUOP_W'(OP_LS)) ALUCtrl_o = ALU_ADD;
      else if (ALUOp_i == ALUOP_W'(OP_BR)) ALUCtrl_o = ALU_SUB;
      else if (ALUOp_i == ALUOP_W'(OP_R))
         ALUCtrl_o = funct7_i == F7_MEXT ? ALU_MDU
                   : funct7_i == F7_BASE ? base_code(funct3_i)
                   : funct7_i != F7_ALT ? ALU_BAD
                   : funct3_i == F3_ADD ? ALU_SUB
                   : funct3_i == F3_SR ? ALU_SRA : ALU_BAD;
      // I-type funct7 is immediate bits except for shifts, where bit 5 picks arithmetic
      else if (ALUOp_i == ALUOP_W'(OP_I))
         ALUCtrl_o = funct3_i == F3_SR && funct7_i[5] ? ALU_SRA : base_code(funct3_i);
   end

   assign is_m   = valid_i & ALUOp_i == ALUOP_W'(OP_R) & funct7_i == F7_MEXT;
   assign accept = is_m & ~flush_i & state == S_IDLE;
   assign run    = (state == S_MUL | state == S_DIV) & ~flush_i;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state <= S_IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:       if (accept) nxt = special ? S_DONE : funct3_i[2] ? S_DIV : S_MUL;
         S_MUL, S_DIV: if (last) nxt = S_DONE;
         default:      nxt = S_IDLE;
      endcase
      if (flush_i) nxt = S_IDLE;
   end

   assign mdu_busy_o = (state == S_IDLE & is_m) | state == S_MUL | state == S_DIV;
   assign mdu_done_o = state == S_DONE & ~flush_i;

   mdu_core #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) u_core (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .start   (accept),
      .run     (run),
      .funct3  (funct3_i),
      .rs1     (rs1_data_i),
      .rs2     (rs2_data_i),
      .special (special),
      .last    (last),
      .result  (mdu_result_o)
   );
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: two DUTs (MUL_BITS 1 and 4) on shared stimulus, checked every cycle
// against a transaction-level model, plus directed literal cases.
module tb_alu_ctrl_mdu;
   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
   logic [6:0] f7 = '0;
   logic [2:0] f3 = '0, op = '0;
   logic [31:0] a = '0, b = '0;
   logic [3:0] ctrl [2];
   logic [1:0] busy, done;
   logic [31:0] res [2];
   logic [31:0] base_tab = 32'h3150_9842;
   int checks = 0, errors = 0;
   int ph [2], lat [2];
   logic [31:0] pend [2], mres [2];
   wire is_m = valid && op == 3'b010 && f7 == 7'b0000001;

   always #5 clk = ~clk;

   alu_ctrl_mdu #(.XLEN(32), .ALUOP_W(3), .MUL_BITS(1)) u_mb1 (
      .clk_i(clk), .rst_n_i(rst_n), .funct7_i(f7), .funct3_i(f3), .ALUOp_i(op),
      .valid_i(valid), .flush_i(flush), .rs1_data_i(a), .rs2_data_i(b),
      .ALUCtrl_o(ctrl[0]), .mdu_busy_o(busy[0]), .mdu_done_o(done[0]), .mdu_result_o(res[0]));

   alu_ctrl_mdu #(.XLEN(32), .ALUOP_W(3), .MUL_BITS(4)) u_mb4 (
      .clk_i(clk), .rst_n_i(rst_n), .funct7_i(f7), .funct3_i(f3), .ALUOp_i(op),
      .valid_i(valid), .flush_i(flush), .rs1_data_i(a), .rs2_data_i(b),
      .ALUCtrl_o(ctrl[1]), .mdu_busy_o(busy[1]), .mdu_done_o(done[1]), .mdu_result_o(res[1]));

   function automatic logic [3:0] ref_ctrl(input logic [2:0] o, input logic [6:0] g, input logic [2:0] h);
      logic [3:0] base;
      base = base_tab[h*4 +: 4];
      if (o == 3'd0) return 4'b0010;
      if (o == 3'd1) return 4'b0110;
      if (o == 3'd3) return (h == 3'd5 && g[5]) ? 4'b0111 : base;
      if (o != 3'd2) return 4'b1111;
      if (g == 7'h01) return 4'b1110;
      if (g == 7'h00) return base;
      if (g == 7'h20 && h == 3'd0) return 4'b0110;
      if (g == 7'h20 && h == 3'd5) return 4'b0111;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, ux, uy;
      logic [63:0] p;
      logic ovf;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
      case (f)
         3'd0: begin p = 64'(sx * sy); return p[31:0]; end
         3'd1: begin p = 64'(sx * sy); return p[63:32]; end
         3'd2: begin p = 64'(sx * uy); return p[63:32]; end
         3'd3: begin p = 64'(ux * uy); return p[63:32]; end
         3'd4: return y == 0 ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
         3'd5: return y == 0 ? 32'hFFFF_FFFF : x / y;
         3'd6: return y == 0 ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
         default: return y == 0 ? x : x % y;
      endcase
   endfunction

   // cycles from accept to the done cycle: 1 for divide-by-zero/overflow, else N+1
   function automatic int ref_lat(input int k, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
      return f[2] ? 33 : (k == 1 ? 8 : 32) + 1;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         5: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n)
      for (int k = 0; k < 2; k++)
         if (!rst_n) begin
            ph[k] <= 0;
            mres[k] <= '0;
         end else if (flush) ph[k] <= 0;
         else if (ph[k] == 0) begin
            if (is_m) begin
               ph[k] <= 1;
               lat[k] <= ref_lat(k, f3, a, b);
               pend[k] <= ref_m(f3, a, b);
               if (ref_lat(k, f3, a, b) == 1) mres[k] <= ref_m(f3, a, b);
            end
         end else if (ph[k] == lat[k]) ph[k] <= 0;
         else begin
            ph[k] <= ph[k] + 1;
            if (ph[k] + 1 == lat[k]) mres[k] <= pend[k];
         end

   always @(negedge clk)
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("ctrl%0d", k), 32'(ctrl[k]), 32'(ref_ctrl(op, f7, f3)));
         chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(ph[k] == 0 ? is_m : ph[k] < lat[k]));
         chk($sformatf("done%0d", k), 32'(done[k]), 32'(ph[k] != 0 && ph[k] == lat[k] && !flush));
         chk($sformatf("result%0d", k), res[k], mres[k]);
      end

   task automatic settle();
      valid = 1'b0;
      flush = 1'b0;
      repeat (40) @(posedge clk);
      #1;
   endtask

   task automatic dec(input logic [2:0] o, input logic [6:0] g, input logic [2:0] h, input logic v,
                      input logic [3:0] e, input string name);
      @(posedge clk); #1;
      op = o; f7 = g; f3 = h; valid = v;
      @(negedge clk);
      chk({name, " ctrl"}, 32'(ctrl[0]), 32'(e));
      chk({name, " busy"}, 32'(busy[0]), 32'(0));
   endtask

   task automatic run_m(input int k, input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input int exp_t, input string name);
      int t;
      t = 0;
      settle();
      chk({name, " model"}, ref_m(fn, x, y), exp_r);
      valid = 1'b1; op = 3'b010; f7 = 7'b0000001; f3 = fn; a = x; b = y;
      @(negedge clk);
      chk({name, " busy at T"}, 32'(busy[k]), 32'(1));
      while (!done[k] && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk({name, " latency"}, 32'(t), 32'(exp_t));
      chk({name, " result"}, res[k], exp_r);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   initial begin
      int n;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reset result%0d", k), res[k], 32'h0);
         chk($sformatf("reset busy%0d", k), 32'(busy[k]), 32'(0));
         chk($sformatf("reset done%0d", k), 32'(done[k]), 32'(0));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      dec(3'b010, 7'b0100000, 3'd0, 1'b1, 4'b0110, "R sub");
      dec(3'b011, 7'b0000000, 3'd2, 1'b0, 4'b1000, "slti");
      dec(3'b001, 7'b0000000, 3'd0, 1'b0, 4'b0110, "branch");
      dec(3'b010, 7'b0000000, 3'd3, 1'b0, 4'b1001, "sltu");
      dec(3'b011, 7'b0100000, 3'd5, 1'b0, 4'b0111, "srai");
      dec(3'b010, 7'b0100000, 3'd1, 1'b0, 4'b1111, "alt illegal");
      dec(3'b110, 7'b0000000, 3'd0, 1'b0, 4'b1111, "bad aluop");

      run_m(0, 3'd0, 32'd7, -32'd3, 32'hFFFF_FFEB, 33, "MUL mb1");
      run_m(1, 3'd0, 32'd7, -32'd3, 32'hFFFF_FFEB, 9, "MUL mb4");
      run_m(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
      run_m(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, "MULH");
      run_m(1, 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 9, "MULHSU mb4");
      run_m(0, 3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU");
      run_m(0, 3'd6, -32'd7, 32'd2, 32'hFFFF_FFFF, 33, "REM neg");
      run_m(1, 3'd4, -32'd100, 32'd7, -32'd14, 33, "DIV neg mb4");
      run_m(0, 3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU");

      // flush at DIV iteration 10: no done, result keeps the DIVU value
      settle();
      valid = 1'b1; op = 3'b010; f7 = 7'b0000001; f3 = 3'd4; a = 32'd1000; b = 32'd3;
      repeat (10) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; valid = 1'b0;
      @(negedge clk);
      chk("flush busy", 32'(busy[0]), 32'(0));
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[0]) n++;
      end
      chk("flush no done", 32'(n), 32'(0));
      chk("flush result", res[0], 32'd14);

      run_m(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIV by 0");
      run_m(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, "REM by 0");
      run_m(1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf mb4");
      run_m(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "REM ovf");

      // asynchronous reset in the middle of a multiply
      settle();
      valid = 1'b1; op = 3'b010; f7 = 7'b0000001; f3 = 3'd0; a = 32'd123; b = 32'd456;
      repeat (5) @(posedge clk);
      #2; rst_n = 1'b0; valid = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("midreset result%0d", k), res[k], 32'h0);
         chk($sformatf("midreset busy%0d", k), 32'(busy[k]), 32'(0));
         chk($sformatf("midreset done%0d", k), 32'(done[k]), 32'(0));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         valid = $urandom_range(0, 3) != 0;
         op = $urandom_range(0, 1) != 0 ? 3'b010 : 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         f3 = 3'($urandom);
         a = pick();
         b = pick();
         flush = $urandom_range(0, 63) == 0;
         rst_n = $urandom_range(0, 999) != 0;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      settle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
